// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings and defaults for the ALU operand stages.
// Mode/state encodings, default source count and byte-source mask, source index names.
package alu_operand_stage_pkg;

    localparam int NUM_SRC_DEF = 6;
    localparam logic [NUM_SRC_DEF-1:0] BYTE_SRC_MASK_DEF = 6'b010001;

    localparam int SRC_REGFILE_8BIT  = 0;
    localparam int SRC_REGFILE_16BIT = 1;
    localparam int SRC_MEM_ADDR      = 2;
    localparam int SRC_MEM_DIN       = 3;
    localparam int SRC_INT_CTRL      = 4;
    localparam int SRC_PC            = 5;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'd0,
        MODE_BYTE_PAIR = 2'd1,
        MODE_SEXT8     = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    // Reserved encoding decodes as DIRECT but is reported.
    function automatic logic mode_is_rsvd(input mode_e m);
        return m == MODE_RSVD;
    endfunction

endpackage

// File: rtl/onehot_prio_sel.sv
// Priority source select: highest set select bit wins, none set picks source 0.
// Latency: combinational, no state.
// Backpressure: none; pure function of select and source bus.
module onehot_prio_sel #(
    parameter int N = 6,
    parameter int W = 16,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] src_dat,
    output logic [IDX_W-1:0] idx,
    output logic [W-1:0]   sel_dat,
    output logic           multi_hot
);

    always_comb begin
        idx     = '0;
        sel_dat = src_dat[W-1:0];
        for (int i = 1; i < N; i++) begin
            if (sel[i]) begin
                idx     = IDX_W'(i);
                sel_dat = src_dat[i*W +: W];
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more were set.
    assign multi_hot = |(sel & (sel - N'(1)));

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand-A select with width extension, byte-pair assembly and byte sign-extend.
// Latency: 1 cycle after acceptance (BYTE_PAIR: 1 cycle after the second beat).
// Backpressure: in_ready drops while a finished operand waits on out_ready; no bubble on drain+refill.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter logic [NUM_SRC-1:0] BYTE_SRC_MASK = NUM_SRC'(BYTE_SRC_MASK_DEF)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC-1:0]        data_select,
    input  logic [1:0]                mode,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         data_out,
    output logic                      sel_err,
    output logic                      mode_err,
    input  logic                      err_clr
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [IDX_W-1:0]  src_idx;
    logic [DATA_W-1:0] sel_dat;
    logic [DATA_W-1:0] raw;
    logic              multi_hot;

    state_e            state_q, state_d;
    logic [7:0]        lo_q, lo_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              sel_err_q, sel_err_d;
    logic              mode_err_q, mode_err_d;

    mode_e             mode_in;
    logic              accept;
    logic              first_beat;

    onehot_prio_sel #(
        .N (NUM_SRC),
        .W (DATA_W)
    ) u_sel (
        .sel       (data_select),
        .src_dat   (src_data),
        .idx       (src_idx),
        .sel_dat   (sel_dat),
        .multi_hot (multi_hot)
    );

    assign raw = BYTE_SRC_MASK[src_idx] ? DATA_W'(sel_dat[7:0]) : sel_dat;

    assign mode_in    = mode_e'(mode);
    assign in_ready   = (state_q != ST_FULL) || out_ready;
    assign accept     = in_valid && in_ready && !flush;
    // In FULL a beat is only accepted alongside out_ready, so it starts fresh.
    assign first_beat = (state_q != ST_WAIT_HI);

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        dout_d  = dout_q;

        if (state_q == ST_FULL && out_ready) begin
            state_d = ST_IDLE;
        end

        if (accept) begin
            if (!first_beat) begin
                dout_d  = DATA_W'({raw[7:0], lo_q});
                state_d = ST_FULL;
            end else begin
                case (mode_in)
                    MODE_BYTE_PAIR: begin
                        lo_d    = raw[7:0];
                        state_d = ST_WAIT_HI;
                    end
                    MODE_SEXT8: begin
                        dout_d  = DATA_W'($signed(raw[7:0]));
                        state_d = ST_FULL;
                    end
                    default: begin
                        dout_d  = raw;
                        state_d = ST_FULL;
                    end
                endcase
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
            lo_d    = '0;
        end

        sel_err_d  = (accept && multi_hot) || (sel_err_q && !err_clr);
        mode_err_d = (accept && first_beat && mode_is_rsvd(mode_in)) ||
                     (mode_err_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lo_q       <= '0;
            dout_q     <= '0;
            sel_err_q  <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            dout_q     <= dout_d;
            sel_err_q  <= sel_err_d;
            mode_err_q <= mode_err_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign data_out  = dout_q;
    assign sel_err   = sel_err_q;
    assign mode_err  = mode_err_q;

endmodule
